// File: rtl/ingress_port_scheduler_if.sv
// ---------------------------------------------------------------------------
// ingress_port_scheduler_if
// Bundle of the signals shared by the ingress port scheduler, the per-port
// ingress FIFO controllers (occupancy, enables) and the line card FIFO reader
// (grant handshake, completion, statistics).
//
// Handshake: grant_valid/grant_port are driven by the scheduler. A grant
// transfers in the cycle where grant_valid and grant_ready are both high.
// Once grant_valid rises, grant_port holds steady and grant_valid stays high
// until that transfer. grant_done is a one-cycle pulse from the reader that
// closes the transferred grant.
//
// Modports:
//   master - scheduler side (drives grant_valid, grant_port, timeout_err,
//            stats_count)
//   slave  - FIFO controller / reader side (drives fifo_rd_size,
//            port_enable, grant_ready, grant_done, stats_sel)
// ---------------------------------------------------------------------------
interface ingress_port_scheduler_if #(
  parameter int NUM_PORTS = 24
);
  logic [12:0] fifo_rd_size [NUM_PORTS];
  logic [NUM_PORTS-1:0] port_enable;
  logic        grant_valid;
  logic [4:0]  grant_port;
  logic        grant_ready;
  logic        grant_done;
  logic        timeout_err;
  logic [4:0]  stats_sel;
  logic [31:0] stats_count;

  modport master (
    input  fifo_rd_size,
    input  port_enable,
    input  grant_ready,
    input  grant_done,
    input  stats_sel,
    output grant_valid,
    output grant_port,
    output timeout_err,
    output stats_count
  );

  modport slave (
    output fifo_rd_size,
    output port_enable,
    output grant_ready,
    output grant_done,
    output stats_sel,
    input  grant_valid,
    input  grant_port,
    input  timeout_err,
    input  stats_count
  );
endinterface

// File: rtl/ingress_port_scheduler.sv
// ---------------------------------------------------------------------------
// ingress_port_scheduler
// Frame-granular round-robin scheduler sharing one UltraRAM read port among
// NUM_PORTS ingress FIFOs. A non-empty, enabled port is granted and keeps the
// read port until the frame reader pulses grant_done, or until the watchdog
// revokes the grant after TIMEOUT_CYCLES cycles in BUSY.
//
// Parameters:
//   NUM_PORTS      - ports arbitrated (2..32)
//   TIMEOUT_CYCLES - BUSY watchdog limit; 0 disables the watchdog
//
// Ports:
//   clk         - fabric clock
//   rst         - synchronous active-high reset
//   bus         - ingress_port_scheduler_if.master (occupancy, enables,
//                 grant handshake, done, timeout, statistics)
//   dbg_state_o - current FSM state (0 IDLE, 1 GRANT, 2 BUSY)
//
// Optional build: define INGRESS_SCHED_STATS_EN to build per-port 32-bit
// grant counters readable through stats_sel/stats_count. Without it,
// stats_count is tied to 0 and stats_sel is ignored.
// ---------------------------------------------------------------------------
module ingress_port_scheduler #(
  parameter int NUM_PORTS      = 24,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                            clk,
  input  logic                            rst,
  ingress_port_scheduler_if.master        bus,
  output logic [1:0]                      dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_BUSY  = 2'd2
  } state_t;

  // A zero limit still needs a legal 1-bit counter; the watchdog is then
  // never allowed to fire.
  localparam int WD_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES);
  localparam logic [4:0] LAST_RST = 5'(NUM_PORTS - 1);

  state_t                 state_q, state_d;
  logic [NUM_PORTS-1:0]   elig_q, elig_d;
  logic [4:0]             last_q, last_d;
  logic [4:0]             gport_q, gport_d;
  logic [WD_W-1:0]        wdog_q, wdog_d;
  logic                   tout_q, tout_d;

  logic                   sel_found;
  logic [4:0]             sel_idx;
  logic [31:0]            elig_w;

  // Eligibility is registered to break the path from the FIFO controllers.
  always_comb begin
    elig_d = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      elig_d[i] = (bus.fifo_rd_size[i] != 13'd0) && bus.port_enable[i];
    end
  end

  // Round-robin search starting one past the last granted port; the last
  // granted port is visited last (k == NUM_PORTS).
  always_comb begin
    logic [5:0] cand;
    elig_w    = 32'(elig_q);
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      cand = {1'b0, last_q} + 6'(k);
      if (cand >= 6'(NUM_PORTS)) begin
        cand = cand - 6'(NUM_PORTS);
      end
      if (!sel_found && elig_w[cand[4:0]]) begin
        sel_found = 1'b1;
        sel_idx   = cand[4:0];
      end
    end
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    gport_d = gport_q;
    wdog_d  = wdog_q;
    tout_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (sel_found) begin
          gport_d = sel_idx;
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        // Grant is held here until accepted, even if the port drains.
        if (bus.grant_ready) begin
          last_d  = gport_q;
          wdog_d  = '0;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (wdog_q != WD_MAX) begin
          wdog_d = wdog_q + WD_W'(1);
        end
        // Completion takes precedence over a coincident watchdog expiry.
        if (bus.grant_done) begin
          state_d = S_IDLE;
        end else if ((TIMEOUT_CYCLES != 0) && (wdog_d == WD_MAX)) begin
          tout_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      elig_q  <= '0;
      last_q  <= LAST_RST;
      gport_q <= '0;
      wdog_q  <= '0;
      tout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      elig_q  <= elig_d;
      last_q  <= last_d;
      gport_q <= gport_d;
      wdog_q  <= wdog_d;
      tout_q  <= tout_d;
    end
  end

  assign bus.grant_valid = (state_q == S_GRANT);
  assign bus.grant_port  = gport_q;
  assign bus.timeout_err = tout_q;
  assign dbg_state_o     = state_q;

`ifdef INGRESS_SCHED_STATS_EN
  logic [31:0] cnt_q [NUM_PORTS];
  logic [31:0] stats_d, stats_q;
  logic        hs;

  assign hs = (state_q == S_GRANT) && bus.grant_ready;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_cnt
    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_q[p] <= '0;
      end else if (hs && (gport_q == 5'(p))) begin
        cnt_q[p] <= cnt_q[p] + 32'd1;  // wraps modulo 2^32
      end
    end
  end

  // Out-of-range selections fall through to zero.
  always_comb begin
    stats_d = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (bus.stats_sel == 5'(p)) begin
        stats_d = cnt_q[p];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stats_q <= '0;
    end else begin
      stats_q <= stats_d;
    end
  end

  assign bus.stats_count = stats_q;
`else
  logic unused_stats_sel;
  assign unused_stats_sel = ^bus.stats_sel;
  assign bus.stats_count  = '0;
`endif

endmodule

// File: tb/tb_ingress_port_scheduler.sv
// ---------------------------------------------------------------------------
// tb_ingress_port_scheduler
// Directed bench for ingress_port_scheduler (NUM_PORTS=24, TIMEOUT_CYCLES=16).
// Stimulus pushes the expected grant port into exp_q; a monitor pops and
// compares on every accepted grant.
// ---------------------------------------------------------------------------
module tb_ingress_port_scheduler;
  localparam int NP = 24;
  localparam int TO = 16;
`ifdef INGRESS_SCHED_STATS_EN
  localparam int STATS_EXP = 5;
`else
  localparam int STATS_EXP = 0;
`endif

  // Clock / reset
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  ingress_port_scheduler_if #(.NUM_PORTS(NP)) bus ();

  ingress_port_scheduler #(
    .NUM_PORTS      (NP),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  int n_checks  = 0;
  int n_fail    = 0;
  int to_count  = 0;
  logic [4:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (!rst && bus.grant_valid && bus.grant_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_grant: got port %0d, expected no grant", bus.grant_port);
      end else begin
        check("grant_port", 32'(bus.grant_port), 32'(exp_q.pop_front()));
      end
    end
    if (!rst && bus.timeout_err) to_count++;
  end

  // Driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic wait_busy(input string name);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (dbg_state == 2'd2) return;
    end
    n_checks++;
    n_fail++;
    $display("FAIL %s: got no BUSY state, expected BUSY within 40 cycles", name);
  endtask

  task automatic pulse_done(input int clr_port);
    @(posedge clk);
    #1;
    bus.grant_done = 1'b1;
    if (clr_port >= 0) bus.fifo_rd_size[clr_port] = 13'd0;
    @(posedge clk);
    #1;
    bus.grant_done = 1'b0;
  endtask

  // Global time limit
  initial begin
    #200000;
    $display("FAIL global_timeout: got simulation still running, expected completion");
    $fatal(1, "bench time limit");
  end

  initial begin
    int n;
    int seen;
    for (int i = 0; i < NP; i++) bus.fifo_rd_size[i] = 13'd0;
    bus.port_enable = '1;
    bus.grant_ready = 1'b1;
    bus.grant_done  = 1'b0;
    bus.stats_sel   = 5'd0;

    // Reset state
    do_reset();
    @(negedge clk);
    check("rst_grant_valid", 32'(bus.grant_valid), 0);
    check("rst_grant_port",  32'(bus.grant_port), 0);
    check("rst_timeout_err", 32'(bus.timeout_err), 0);
    check("rst_stats_count", bus.stats_count, 0);
    check("rst_state",       32'(dbg_state), 0);

    // Single port: valid rises two cycles after the occupancy change
    @(posedge clk); #1;
    bus.fifo_rd_size[5] = 13'd10;
    exp_q.push_back(5'd5);
    @(negedge clk);
    check("lat_valid_c0", 32'(bus.grant_valid), 0);
    @(negedge clk);
    check("lat_valid_c1", 32'(bus.grant_valid), 0);
    @(negedge clk);
    check("lat_valid_c2", 32'(bus.grant_valid), 1);
    @(negedge clk);
    check("lat_busy", 32'(dbg_state), 2);
    check("busy_valid_low", 32'(bus.grant_valid), 0);
    pulse_done(5);

    // Round robin across 3, 7, 23
    do_reset();
    bus.fifo_rd_size[3]  = 13'd20;
    bus.fifo_rd_size[7]  = 13'd20;
    bus.fifo_rd_size[23] = 13'd20;
    for (int r = 0; r < 2; r++) begin
      exp_q.push_back(5'd3);
      exp_q.push_back(5'd7);
      exp_q.push_back(5'd23);
    end
    for (int i = 0; i < 6; i++) begin
      wait_busy("rr_busy");
      tick(3);
      if (i == 5) begin
        bus.fifo_rd_size[3] = 13'd0;
        bus.fifo_rd_size[7] = 13'd0;
      end
      pulse_done(i == 5 ? 23 : -1);
    end
    tick(4);
    check("rr_idle", 32'(dbg_state), 0);
    check("rr_queue_empty", 32'(exp_q.size()), 0);

    // Disabled port is never granted, enabling it grants within 3 cycles
    bus.port_enable[9]  = 1'b0;
    bus.fifo_rd_size[9] = 13'd5;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.grant_valid) seen++;
    end
    check("disabled_no_grant", 32'(seen), 0);
    @(posedge clk); #1;
    exp_q.push_back(5'd9);
    bus.port_enable[9] = 1'b1;
    n = 0;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      if (bus.grant_valid) begin
        n = i;
        break;
      end
    end
    check("enable_grant_cycles", 32'(n), 3);
    wait_busy("en_busy");
    pulse_done(9);

    // Watchdog: port 2 is held without done and revoked after 16 BUSY cycles
    do_reset();
    bus.fifo_rd_size[2]  = 13'd8;
    bus.fifo_rd_size[4]  = 13'd8;
    bus.fifo_rd_size[12] = 13'd8;
    exp_q.push_back(5'd2);
    exp_q.push_back(5'd4);
    exp_q.push_back(5'd12);
    exp_q.push_back(5'd2);
    wait_busy("to_busy");
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (bus.timeout_err) begin
        n = i;
        break;
      end
    end
    check("timeout_cycle", 32'(n), TO);
    @(negedge clk);
    check("timeout_single_pulse", 32'(bus.timeout_err), 0);
    wait_busy("to_next4");
    pulse_done(4);
    wait_busy("to_next12");
    pulse_done(12);
    wait_busy("to_again2");

    // grant_done coinciding with the watchdog expiry cycle
    repeat (TO - 1) @(posedge clk);
    #1;
    bus.grant_done = 1'b1;
    bus.fifo_rd_size[2] = 13'd0;
    @(posedge clk); #1;
    bus.grant_done = 1'b0;
    @(negedge clk);
    check("coincide_no_timeout", 32'(bus.timeout_err), 0);
    check("coincide_idle", 32'(dbg_state), 0);
    check("timeout_total", 32'(to_count), 1);

    // Reset mid-BUSY, port 0 wins afterwards
    bus.fifo_rd_size[0]  = 13'd6;
    bus.fifo_rd_size[10] = 13'd6;
    exp_q.push_back(5'd10);
    wait_busy("rb_busy");
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q.push_back(5'd0);
    @(negedge clk);
    check("rb_valid_low", 32'(bus.grant_valid), 0);
    @(posedge clk); #1;
    check("rb_state_idle", 32'(dbg_state), 0);
    check("rb_timeout_low", 32'(bus.timeout_err), 0);
    rst = 1'b0;
    wait_busy("rb_next");
    bus.fifo_rd_size[10] = 13'd0;
    pulse_done(0);

    // Grant statistics for port 4
    do_reset();
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      bus.fifo_rd_size[4] = 13'd3;
      exp_q.push_back(5'd4);
      wait_busy("st_busy");
      pulse_done(4);
    end
    tick(2);
    bus.stats_sel = 5'd4;
    tick(2);
    @(negedge clk);
    check("stats_port4", bus.stats_count, STATS_EXP);
    bus.stats_sel = 5'd30;
    tick(2);
    @(negedge clk);
    check("stats_out_of_range", bus.stats_count, 0);

    // Drain
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    check("final_queue_empty", 32'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/ingress_port_scheduler.md
# ingress_port_scheduler

Frame-granular round-robin scheduler that shares the single cascaded UltraRAM read port of a line card among its 24 per-port ingress FIFOs. Each cycle it watches the per-port FIFO occupancy reported by the ingress FIFO controllers and grants the read port to one non-empty, enabled port at a time. It holds that grant until the downstream frame reader reports the frame fully consumed. It sits between the per-port ingress FIFO controllers and the line card FIFO reader, all in the fabric clock domain.

## Interface
Parameters:
- NUM_PORTS, 24, number of ingress FIFOs arbitrated (supported range 2..32)
- TIMEOUT_CYCLES, 4096, maximum cycles in BUSY before the grant is forcibly revoked; 0 disables the watchdog

Ports:
- clk  input  1  fabric clock; one clock for the whole block
- rst  input  1  synchronous, active-high reset
- fifo_rd_size[NUM_PORTS-1:0]  input  13 each  words pending in each ingress FIFO
- port_enable  input  NUM_PORTS  per-port scheduling enable (1 = eligible)
- grant_valid  output  1  a grant is offered
- grant_port  output  5  index of the granted port
- grant_ready  input  1  reader accepts the grant (valid/ready handshake)
- grant_done  input  1  single-cycle pulse: reader finished the granted frame
- timeout_err  output  1  single-cycle pulse: watchdog revoked a grant
- stats_sel  input  5  port whose grant counter is shown (stats build only)
- stats_count  output  32  grant count for stats_sel (stats build only)

## Operation
- Port p is eligible when fifo_rd_size[p] != 0 and port_enable[p] is 1. The eligible vector is registered each cycle.
- last_port holds the most recently granted index and resets to NUM_PORTS-1, so port 0 has top priority after reset.
- The search starts at last_port+1 and wraps from NUM_PORTS-1 to 0. It picks the first eligible port. last_port itself has the lowest priority.
- State machine:
  - IDLE: if any port is eligible, latch the selected index into grant_port and go to GRANT.
  - GRANT: grant_valid=1. On grant_ready=1, set last_port=grant_port, clear the watchdog, and go to BUSY.
  - BUSY: grant_valid=0. On grant_done=1, go to IDLE. If the watchdog reaches TIMEOUT_CYCLES, pulse timeout_err for one cycle and go to IDLE.
- A grant is never retracted once offered. grant_port stays stable in GRANT even if that port becomes ineligible.
- grant_done is ignored outside BUSY.
- If grant_done and the watchdog expiry coincide, done wins and timeout_err stays 0.
- Watchdog counter width is $clog2(TIMEOUT_CYCLES+1). It counts only in BUSY and saturates at TIMEOUT_CYCLES.

## Timing
- Reset values: grant_valid=0, grant_port=0, timeout_err=0, stats_count=0, state=IDLE, last_port=NUM_PORTS-1, watchdog=0, all grant counters 0.
- Latency from a fifo_rd_size / port_enable change to an eligibility update: 1 cycle (registered).
- Latency from eligibility to grant_valid: eligible in cycle N → IDLE select in cycle N+1 → grant_valid high in cycle N+2.
- Handshake: the handshake completes in the cycle where grant_valid and grant_ready are both high. BUSY starts the next cycle.
- After grant_done, the block spends one IDLE cycle before the next grant can be offered. This absorbs the rd_size update lag.
- Reset at any point, including mid-BUSY, returns to IDLE on the next edge. No grant_valid or timeout_err pulse is produced.

## Configuration
- Macro: INGRESS_SCHED_STATS_EN
- Defined:
  - A per-port 32-bit grant counter increments on each completed handshake and wraps modulo 2^32.
  - stats_count is the registered counter for stats_sel, with 1-cycle latency.
  - A stats_sel value ≥ NUM_PORTS reads 0.
- Undefined: no counters are built, stats_sel is ignored, and stats_count is tied to 0.

## Test plan
- After reset, set fifo_rd_size[5]=10 with all ports enabled, and hold grant_ready=1 → grant_valid rises 2 cycles later with grant_port=5; BUSY follows.
- Ports 3, 7 and 23 are non-empty and each grant_done is pulsed 4 cycles after its grant → grants occur in the order 3, 7, 23, 3, 7, 23 with no repeats while others are eligible.
- Port 9 is non-empty with port_enable[9]=0 → no grant. Raising port_enable[9] → grant_port=9 within 3 cycles.
- With TIMEOUT_CYCLES=16, grant port 2 and never pulse grant_done → timeout_err pulses exactly once, 16 cycles into BUSY. The next grant goes to another eligible port, and port 2 is granted again only after all others.
- grant_done and watchdog expiry in the same cycle → timeout_err=0 and the state returns to IDLE. Asserting rst during BUSY → grant_valid=0 and the next grant is taken by port 0 if it is eligible.
- With INGRESS_SCHED_STATS_EN: 5 completed grants to port 4 → stats_sel=4 reads 5 and stats_sel=30 reads 0. Without the macro, stats_count stays 0 throughout.
